// File: rtl/chirp_source.sv
// chirp_source: linear-frequency sweep generator feeding a 3-stage 4x(1-x) sine pipeline.
module chirp_source #(
   parameter int WIDTH   = 16,
   parameter int PHASE_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      start,
   input  logic [PHASE_W-1:0]        freqStart,
   input  logic [PHASE_W-1:0]        freqStep,
   input  logic [31:0]               length,
   output logic                      busy,
   output logic                      done,
   output logic signed [WIDTH-1:0]   out,
   output logic                      outValid
);
   localparam int N = WIDTH - 1;
   localparam logic [2*N:0] FULL = (2*N+1)'(1) << N;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
   state_t state, state_nx;
   logic [PHASE_W-1:0] phase, freq, step;
   logic [31:0] count;
   logic accept, zero_req, issue, last;
   logic [N-1:0] x1;
   logic sign1, v1, l1;
   logic [2*N:0] xw, m2;
   logic sign2, v2, l2;
   logic [N+2:0] mag_raw;
   logic [N-1:0] mag;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? RUN : IDLE;
         RUN:     state_nx = (issue && last) ? DRAIN : RUN;
         DRAIN:   state_nx = done ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      accept   = state == IDLE && start && length != '0;
      zero_req = state == IDLE && start && length == '0;
      issue    = state == RUN && en;
      last     = count == 32'd1;
      busy     = state != IDLE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         phase <= '0;
         freq  <= '0;
         step  <= '0;
         count <= '0;
      end else if (accept) begin
         phase <= '0;
         freq  <= freqStart;
         step  <= freqStep;
         count <= length;
      end else if (issue) begin
         phase <= phase + freq;
         freq  <= freq + step;
         count <= count - 32'd1;
      end
   // S1: fold phase into half-cycle position x and sign
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         x1    <= '0;
         sign1 <= 1'b0;
         v1    <= 1'b0;
         l1    <= 1'b0;
      end else begin
         x1    <= phase[PHASE_W-2 -: N];
         sign1 <= phase[PHASE_W-1];
         v1    <= issue;
         l1    <= issue && last;
      end
   always_comb begin
      xw      = {{(N+1){1'b0}}, x1};
      mag_raw = m2[2*N:N-2];
      mag     = |mag_raw[N+2:N] ? '1 : mag_raw[N-1:0];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         m2    <= '0;
         sign2 <= 1'b0;
         v2    <= 1'b0;
         l2    <= 1'b0;
      end else begin
         m2    <= xw * (FULL - xw);
         sign2 <= sign1;
         v2    <= v1;
         l2    <= l1;
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         out      <= '0;
         outValid <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (v2) out <= sign2 ? -{1'b0, mag} : {1'b0, mag};
         outValid <= v2;
         done     <= (v2 && l2) || zero_req;
      end
endmodule

// File: tb/tb_chirp_source.sv
// tb_chirp_source: scoreboard bench for chirp_source sweeps, gating, start contention and reset abort.
module tb_chirp_source;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic start = 1'b0;
   logic [31:0] freqStart = '0;
   logic [31:0] freqStep = '0;
   logic [31:0] length = '0;
   logic busy, done, outValid;
   logic signed [15:0] out;
   typedef struct {int v; bit d; int at; bit ov;} exp_t;
   exp_t sb[$];
   int ev[8];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int npop = 0;
   chirp_source dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .freqStart(freqStart), .freqStep(freqStep), .length(length),
      .busy(busy), .done(done), .out(out), .outValid(outValid)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst && (outValid || done)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output out=%0d outValid=%0b done=%0b expected none", out, outValid, done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            npop++;
            chk("outValid", int'(outValid), int'(e.ov));
            if (e.ov) chk("out", int'(out), e.v);
            chk("done", int'(done), int'(e.d));
            chk("arrival_cycle", cyc, e.at);
         end
      end
   end
   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask
   task automatic sweep(input logic [31:0] fs, input logic [31:0] fst, input int len, input int gap, input bit poke);
      int issued = 0;
      int k = 0;
      start = 1'b1; freqStart = fs; freqStep = fst; length = len; en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_rise", int'(busy), 1);
      while (issued < len) begin
         en = (k % gap) == 0;
         start = poke && issued == 3;
         if (start) begin
            freqStart = 32'h1234_5678; freqStep = 32'h1; length = 2;
         end
         if (en) begin
            sb.push_back('{ev[issued], issued == len - 1, cyc + 3, 1'b1});
            issued++;
         end
         k++;
         @(posedge clk); #1;
      end
      en = 1'b0;
      start = 1'b0;
      drain();
      chk("busy_fall", int'(busy), 0);
   endtask
   initial begin
      int base;
      #2 rst = 1'b0;
      #1;
      chk("rst_out", int'(out), 0);
      chk("rst_outValid", int'(outValid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      ev = '{0, 24576, 32767, 24576, 0, -24576, -32767, -24576};
      sweep(32'h2000_0000, 32'h0, 8, 1, 1'b0);
      ev = '{0, 0, 3968, 11136, 0, 0, 0, 0};
      sweep(32'h0, 32'h0400_0000, 4, 1, 1'b0);
      ev = '{0, 24576, 32767, 24576, 0, -24576, -32767, -24576};
      sweep(32'h2000_0000, 32'h0, 8, 2, 1'b0);
      start = 1'b1; length = 0; freqStart = 32'h2000_0000;
      sb.push_back('{0, 1'b1, cyc + 1, 1'b0});
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_busy0", int'(busy), 0);
      @(posedge clk); #1;
      chk("zero_busy1", int'(busy), 0);
      drain();
      sweep(32'h2000_0000, 32'h0, 8, 1, 1'b1);
      start = 1'b1; freqStart = 32'h2000_0000; freqStep = 0; length = 8;
      @(posedge clk); #1;
      start = 1'b0;
      base = npop;
      for (int i = 0; i < 8 && npop - base < 3; i++) begin
         en = 1'b1;
         sb.push_back('{ev[i], i == 7, cyc + 3, 1'b1});
         @(posedge clk); #1;
      end
      chk("abort_after_three", npop - base, 3);
      rst = 1'b0;
      en = 1'b0;
      #1;
      chk("abort_out", int'(out), 0);
      chk("abort_outValid", int'(outValid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("abort_hold_done", int'(done), 0);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_busy", int'(busy), 0);
      sweep(32'h2000_0000, 32'h0, 8, 1, 1'b0);
      ev = '{0, -24576, -32767, -24576, 0, 0, 0, 0};
      sweep(32'hE000_0000, 32'h0, 4, 1, 1'b0);
      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/chirp_source.md
# chirp_source

Sample-stream generator driving the `in` port of the single-pole IIR filters. It runs a linear-frequency sweep: a phase accumulator whose increment ramps by a fixed step each sample. Phase is converted to a signed sine approximation, y = 4x(1−x) per half-cycle, through a 3-stage pipeline. This is the hardware stimulus source for on-chip filter characterisation; it replaces the bench-side chirp.

## Interface
- `WIDTH`, 16: output sample width, signed; N = WIDTH−1.
- `PHASE_W`, 32: phase accumulator and frequency word width; must be ≥ WIDTH+1.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  sample strobe; one sample issued per `en` cycle while running.
- `start`  in  1  single-cycle sweep request; sampled only in IDLE.
- `freqStart`  in  PHASE_W  initial phase increment; latched on accepted `start`.
- `freqStep`  in  PHASE_W  per-sample increment change, two's complement; latched on accepted `start`.
- `length`  in  32  number of samples in the sweep; latched on accepted `start`.
- `busy`  out  1  high while a sweep is running or draining.
- `done`  out  1  single-cycle pulse marking sweep completion.
- `out`  out  WIDTH  signed sample; holds its value when `outValid` is low.
- `outValid`  out  1  `out` carries a new sample this cycle.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE + `start` + `length`≠0:
  - latch `freqStep`; phase←0, freq←`freqStart`, count←`length`; go RUN.
  - `busy` rises the next cycle.
- IDLE + `start` + `length`=0: stay IDLE, `busy` stays 0, `done` pulses the next cycle.
- `start` outside IDLE is ignored; the latched parameters are unchanged.
- RUN, on each `en` cycle:
  - issue the current phase into the pipeline, tagged valid; tag it last when count=1.
  - then phase←phase+freq, freq←freq+freqStep, count←count−1.
  - The first sample uses phase 0.
- RUN, count reaches 0: go DRAIN. Cycles with `en` low issue nothing.
- DRAIN: wait for the sample tagged last to reach the output. In that cycle assert `done` with it and go IDLE; `busy` falls the next cycle.
- Arithmetic:
  - phase and freq wrap modulo 2^PHASE_W; no saturation.
  - freq ≥ 2^(PHASE_W−1) aliases, i.e. negative rotation.
- Sine conversion:
  - sign = phase[PHASE_W−1]; x = phase[PHASE_W−2 : PHASE_W−1−N], unsigned, N bits.
  - m = x·(2^N − x), computed at 2N+1 bits, unsigned.
  - mag = m >> (N−2), saturated to 2^N − 1.
  - out = sign ? −mag : mag.
- Pipeline stages:
  - S1 registers x, sign, valid, last.
  - S2 registers m.
  - S3 registers `out`, `outValid` and `done`.
  - The pipeline advances every clock regardless of `en`.

## Timing
- Reset values (immediate on `rst` low, in any state): state IDLE; `out`=0, `outValid`=0, `busy`=0, `done`=0.
- Reset also clears all pipeline valid and last tags, phase, freq and count.
- Latency: `en` sampled in RUN at edge t → `outValid` high in cycle t+3.
- Throughput: one sample per clock with `en` tied high.
- `done` coincides with the final `outValid`.
- Earliest new `start` acceptance: the cycle after `done`.
- Reset during RUN or DRAIN aborts the sweep; no `done` is emitted for it.

## Test plan
- Octant walk: freqStart=2^29, freqStep=0, length=8, `en`=1.
  - `out` = 0, 24576, 32767, 24576, 0, −24576, −32767, −24576 on 8 consecutive `outValid` cycles.
  - first `outValid` 3 clocks after the first RUN `en` cycle.
  - `done` with the 8th sample; `busy` low the following cycle.
- Chirp ramp: freqStart=0, freqStep=2^26, length=4.
  - `out` = 0, 0, 3968, 11136; `done` on the 4th.
- `en` gating: scenario 1 with `en` high every other cycle.
  - same 8 values; `outValid` spaced 2 cycles apart, each exactly 3 cycles after its `en`.
- Degenerate and contended start:
  - `start` with length=0 → `done` 1 cycle later, `busy` never high, no `outValid`.
  - `start` pulsed mid-sweep with different parameters → ignored; sequence unchanged.
- Reset mid-sweep:
  - drop `rst` after the 3rd `outValid` of scenario 1 → all outputs 0 asynchronously, no `done`.
  - restart after release → sequence begins again at 0, 24576, …
- Frequency wrap: freqStart=2^32−2^29, freqStep=0, length=4.
  - `out` = 0, −24576, −32767, −24576.
